// File: rtl/stream_framer_if.sv
// axis_if: AXI-stream style bundle carrying the shared clock/reset with the stream signals
interface axis_if #(
  parameter int CH_NUM     = 2,
  parameter int DATA_WIDTH = 16
) (
  input logic clk_i,
  input logic rst_i
);
  logic                                tvalid;
  logic                                tready;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0]   tdata;
  logic                                tlast;
  modport master (input clk_i, rst_i, tready, output tvalid, tdata, tlast);
  modport slave  (input clk_i, rst_i, tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/stream_framer.sv
// stream_framer: FWFT sample FIFO feeding an AXI-stream master, sticky drop flag, optional
// tlast framing every frame_len_i beats when STREAM_FRAMER_TLAST_EN is defined.
module stream_framer #(
  parameter int CH_NUM      = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WIDTH = 16
) (
  axis_if.master                            m_axis,
  input  logic                              en_i,
  input  logic                              tvalid_i,
  input  logic [CH_NUM-1:0][DATA_WIDTH-1:0] tdata_i,
  input  logic [FRAME_WIDTH-1:0]            frame_len_i,
  input  logic                              clr_i,
  output logic                              overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]       level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic                              clk_i, rst_i;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]                     wr_ptr, rd_ptr;
  logic [AW:0]                       level;
  logic                              req, pop, push, drop, full;
  assign clk_i = m_axis.clk_i;
  assign rst_i = m_axis.rst_i;
  assign full  = level == (AW+1)'(FIFO_DEPTH);
  assign req   = tvalid_i && en_i;
  assign pop   = m_axis.tvalid && m_axis.tready;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push  = req && (!full || pop);
  assign drop  = req && !push;
  assign m_axis.tvalid = level != '0;
  assign m_axis.tdata  = mem[rd_ptr];
  assign level_o       = level;
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= tdata_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level      <= level + (AW+1)'(push) - (AW+1)'(pop);
      overflow_o <= drop || (overflow_o && !clr_i);
    end
  end
`ifdef STREAM_FRAMER_TLAST_EN
  logic [FRAME_WIDTH-1:0] beat_cnt, last_idx;
  assign last_idx    = frame_len_i == '0 ? '0 : frame_len_i - FRAME_WIDTH'(1);
  assign m_axis.tlast = m_axis.tvalid && beat_cnt >= last_idx;
  always_ff @(posedge clk_i) begin
    if (rst_i) beat_cnt <= '0;
    else if (pop) beat_cnt <= m_axis.tlast ? '0 : beat_cnt + 1'b1;
  end
`else
  logic unused_frame_len;
  assign unused_frame_len = ^frame_len_i;
  assign m_axis.tlast     = 1'b0;
`endif
endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: directed stimulus, queue-based reference model, per-cycle compare
module tb_stream_framer;
  localparam int CH = 2, DW = 16, DEPTH = 16, FW = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic en = 1'b0, tv = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [CH-1:0][DW-1:0] td = '0;
  logic [FW-1:0] flen = 16'd4;
  logic ovf;
  logic [4:0] lvl;
  axis_if #(.CH_NUM(CH), .DATA_WIDTH(DW)) m_axis (.clk_i(clk), .rst_i(rst));
  assign m_axis.tready = rdy;
  stream_framer #(.CH_NUM(CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FRAME_WIDTH(FW)) dut (
    .m_axis(m_axis), .en_i(en), .tvalid_i(tv), .tdata_i(td), .frame_len_i(flen),
    .clr_i(clr), .overflow_o(ovf), .level_o(lvl));

  int n_checks = 0, n_err = 0;
  logic [31:0] q[$];
  int beats = 0;
  bit ovf_m = 0, armed = 0;
  logic [31:0] got_d[$];
  bit got_l[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // a frame ends once the beat count reaches max(frame_len, 1)
  function automatic bit exp_last();
`ifdef STREAM_FRAMER_TLAST_EN
    return q.size() != 0 && beats + 1 >= ((flen == 0) ? 1 : int'(flen));
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    bit pop, acc, drp, lst;
    if (m_axis.tvalid && rdy) begin
      got_d.push_back(m_axis.tdata);
      got_l.push_back(m_axis.tlast);
    end
    pop = q.size() != 0 && rdy;
    acc = tv && en && (q.size() < DEPTH || pop);
    drp = tv && en && !acc;
    lst = exp_last();
    if (rst) begin
      q.delete();
      beats = 0;
      ovf_m = 0;
      armed = 1;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        beats = lst ? 0 : beats + 1;
      end
      if (acc) q.push_back(td);
      ovf_m = drp ? 1'b1 : clr ? 1'b0 : ovf_m;
    end
  end

  always @(negedge clk) if (armed) begin
    chk("level", lvl, q.size());
    chk("tvalid", m_axis.tvalid, q.size() != 0);
    chk("overflow", ovf, ovf_m);
    chk("tlast", m_axis.tlast, exp_last());
    if (q.size() != 0) chk("tdata", m_axis.tdata, q[0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      tv = 1'b1;
      td = {16'(i + 100), 16'(i)};
      step();
    end
    tv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    chk("rst_level", lvl, 0);
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_overflow", ovf, 0);

    rdy = 1'b1;
    tv = 1'b1;
    td[0] = 16'h1234;
    td[1] = 16'hABCD;
    step();
    tv = 1'b0;
    @(negedge clk);
    chk("t1_tvalid", m_axis.tvalid, 1);
    chk("t1_data", m_axis.tdata, 32'hABCD1234);
    step();
    @(negedge clk);
    chk("t1_level", lvl, 0);

    do_reset();
    rdy = 1'b0;
    got_d.delete();
    got_l.delete();
    fill(20);
    @(negedge clk);
    chk("t2_level", lvl, 16);
    chk("t2_overflow", ovf, 1);
    rdy = 1'b1;
    repeat (18) step();
    chk("t2_count", got_d.size(), 16);
    for (int i = 0; i < 16; i++) chk("t2_order", got_d[i][15:0], i);

    do_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
    got_d.delete();
    got_l.delete();
    flen = 16'd4;
    for (int i = 0; i < 12; i++) begin
      tv = 1'b1;
      td = 32'(i);
      rdy = 1'($urandom_range(0, 1));
      step();
    end
    tv = 1'b0;
    for (int c = 0; c < 200 && got_d.size() < 12; c++) begin
      rdy = 1'($urandom_range(0, 1));
      step();
    end
    chk("t3_beats", got_d.size(), 12);
    for (int i = 0; i < 12; i++)
`ifdef STREAM_FRAMER_TLAST_EN
      chk("t3_tlast", got_l[i], (i % 4) == 3);
`else
      chk("t3_tlast", got_l[i], 0);
`endif

    do_reset();
    rdy = 1'b0;
    fill(16);
    rdy = 1'b1;
    tv = 1'b1;
    td = 32'h5555AAAA;
    step();
    tv = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    chk("t4_level", lvl, 16);
    chk("t4_overflow", ovf, 0);
    rdy = 1'b1;
    repeat (17) step();

    do_reset();
    flen = 16'd4;
    rdy = 1'b0;
    fill(7);
    rdy = 1'b1;
    step();
    step();
    rdy = 1'b0;
    @(negedge clk);
    chk("t5_level_pre", lvl, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_tvalid", m_axis.tvalid, 0);
    chk("t5_level", lvl, 0);
    got_d.delete();
    got_l.delete();
    flen = 16'd3;
    rdy = 1'b1;
    fill(3);
    repeat (3) step();
    chk("t5_beats", got_l.size(), 3);
`ifdef STREAM_FRAMER_TLAST_EN
    chk("t5_b1", got_l[0], 0);
    chk("t5_b2", got_l[1], 0);
    chk("t5_b3", got_l[2], 1);
`else
    chk("t5_b3", got_l[2], 0);
`endif

    do_reset();
    rdy = 1'b0;
    fill(16);
    tv = 1'b1;
    clr = 1'b1;
    step();
    tv = 1'b0;
    @(negedge clk);
    chk("t6_ovf_keep", ovf, 1);
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("t6_ovf_clr", ovf, 0);
    en = 1'b0;
    tv = 1'b1;
    step();
    tv = 1'b0;
    en = 1'b1;
    @(negedge clk);
    chk("t6_en_off_ovf", ovf, 0);
    chk("t6_en_off_level", lvl, 16);

    do_reset();
    got_d.delete();
    got_l.delete();
    flen = 16'd8;
    rdy = 1'b0;
    fill(6);
    rdy = 1'b1;
    repeat (3) step();
    flen = 16'd2;
    step();
    flen = 16'd0;
    step();
    step();
    chk("t7_beats", got_l.size(), 6);
`ifdef STREAM_FRAMER_TLAST_EN
    chk("t7_b3", got_l[2], 0);
    chk("t7_shrink", got_l[3], 1);
    chk("t7_len0_a", got_l[4], 1);
    chk("t7_len0_b", got_l[5], 1);
`else
    chk("t7_shrink", got_l[3], 0);
`endif
    rdy = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
